// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receiver arbiter slice.
package i2s_pkg;

  // Default sample width; matches the I2S receivers.
  localparam int BITS_PRECISION_DEF = 24;

  // One receiver sample together with its channel flag.
  typedef struct packed {
    logic [BITS_PRECISION_DEF-1:0] data;
    logic                          left_rightn;
  } sample_t;

  // Output register state.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Width of a channel index; never below one bit.
  function automatic int CH_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_rx_arbiter_rr.sv
// Round-robin grant selection: the search starts one past the last grant.
module rr_arbiter
  import i2s_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = CH_W(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     last_grant,
  input  logic              adv,
  output logic [NUM_CH-1:0] gnt,
  output logic [CW-1:0]     gnt_idx,
  output logic              any_gnt
);

  // First requesting channel after last_grant wins; nothing is granted unless adv.
  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    if (adv) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        c = (int'(last_grant) + off) % NUM_CH;
        if (!any_gnt && req[c]) begin
          any_gnt = 1'b1;
          gnt[c]  = 1'b1;
          gnt_idx = CW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/i2s_rx_arbiter.sv
// Collects samples from NUM_CH I2S receivers into one-entry slots and
// serialises them round-robin onto a single registered valid/ready stream.
module i2s_rx_arbiter
  import i2s_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int BITS_PRECISION = BITS_PRECISION_DEF,
  localparam int CW             = CH_W(NUM_CH)
) (
  input  logic                             sck,
  input  logic                             rst,
  input  logic [NUM_CH*BITS_PRECISION-1:0] data_in,
  input  logic [NUM_CH-1:0]                left_rightn,
  input  logic [NUM_CH-1:0]                data_en,
  input  logic [NUM_CH-1:0]                ch_enable,
  input  logic [NUM_CH-1:0]                clr_overrun,
  output logic [BITS_PRECISION-1:0]        out_data,
  output logic [CW-1:0]                    out_ch,
  output logic                             out_left_rightn,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH-1:0]                overrun
);

  typedef struct packed {
    logic [BITS_PRECISION-1:0] data;
    logic                      left_rightn;
  } slot_t;

  slot_t             slot_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ov_q, ov_d;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] gnt;
  logic [CW-1:0]     gnt_idx;
  logic [CW-1:0]     last_grant_q;
  logic              any_gnt;
  logic              free;
  out_state_e        state_q, state_d;
  slot_t             out_q;
  logic [CW-1:0]     out_ch_q;

  // Output register can take a new sample when empty or being drained now.
  assign free = (state_q == EMPTY) || out_ready;
  assign load = data_en & ch_enable;

  // Disabled channels never compete, even if their pend bit is still draining.
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (pend_q & ch_enable),
    .last_grant (last_grant_q),
    .adv        (free),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  // Pending and overrun next state: a load beats a drain, and an overrun set beats a clear.
  always_comb begin
    pend_d = pend_q;
    ov_d   = ov_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ch_enable[i])  pend_d[i] = 1'b0;
      else if (load[i])   pend_d[i] = 1'b1;
      else if (gnt[i])    pend_d[i] = 1'b0;

      if (load[i] && pend_q[i] && !gnt[i]) ov_d[i] = 1'b1;
      else if (clr_overrun[i])             ov_d[i] = 1'b0;
    end
  end

  // Slot capture, pending bits and sticky overrun flags.
  always_ff @(posedge sck) begin
    if (rst) begin
      pend_q <= '0;
      ov_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      ov_q   <= ov_d;
      for (int i = 0; i < NUM_CH; i++)
        if (load[i])
          slot_q[i] <= '{data: data_in[i*BITS_PRECISION +: BITS_PRECISION],
                         left_rightn: left_rightn[i]};
    end
  end

  // Output state: refill on a grant, go empty when free with nothing pending.
  always_comb begin
    state_d = state_q;
    if (free) state_d = any_gnt ? FULL : EMPTY;
  end

  // Output state register.
  always_ff @(posedge sck) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Output register and round-robin pointer; both hold while stalled.
  always_ff @(posedge sck) begin
    if (rst) begin
      out_q        <= '0;
      out_ch_q     <= '0;
      last_grant_q <= CW'(NUM_CH - 1);
    end else if (any_gnt) begin
      out_q        <= slot_q[gnt_idx];
      out_ch_q     <= gnt_idx;
      last_grant_q <= gnt_idx;
    end
  end

  assign out_valid       = (state_q == FULL);
  assign out_data        = out_q.data;
  assign out_left_rightn = out_q.left_rightn;
  assign out_ch          = out_ch_q;
  assign overrun         = ov_q;

endmodule

// File: tb/tb_i2s_rx_arbiter.sv
// Directed plus randomized bench for i2s_rx_arbiter, checked every cycle
// against a behavioural model of the slot / round-robin / output rules.
module tb_i2s_rx_arbiter;

  localparam int N  = 4;
  localparam int BP = 24;
  localparam int CW = 2;

  logic              sck = 1'b0;
  logic              rst;
  logic [N*BP-1:0]   data_in;
  logic [N-1:0]      left_rightn, data_en, ch_enable, clr_overrun;
  logic [BP-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_left_rightn, out_valid, out_ready;
  logic [N-1:0]      overrun;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  bit          m_pend [N];
  logic [BP-1:0] m_sd [N];
  bit          m_sl   [N];
  bit [N-1:0]  m_ov;
  bit          m_valid;
  logic [BP-1:0] m_data;
  int          m_ch;
  bit          m_lr;
  int          m_lg;

  i2s_rx_arbiter #(.NUM_CH(N), .BITS_PRECISION(BP)) dut (
    .sck             (sck),
    .rst             (rst),
    .data_in         (data_in),
    .left_rightn     (left_rightn),
    .data_en         (data_en),
    .ch_enable       (ch_enable),
    .clr_overrun     (clr_overrun),
    .out_data        (out_data),
    .out_ch          (out_ch),
    .out_left_rightn (out_left_rightn),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .overrun         (overrun)
  );

  always #5 sck = ~sck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one rising edge's worth of the rules to the model, using the inputs now driven.
  task automatic model_step();
    bit free, set, ld;
    int g, c;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_sd[i] = '0; m_sl[i] = 0; end
      m_ov = '0; m_valid = 0; m_data = '0; m_ch = 0; m_lr = 0; m_lg = N - 1;
    end else begin
      free = !m_valid || out_ready;
      g = -1;
      if (free) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_lg + k) % N;
          if (g < 0 && m_pend[c] && ch_enable[c]) g = c;
        end
        if (g >= 0) begin
          m_data = m_sd[g]; m_lr = m_sl[g]; m_ch = g; m_valid = 1; m_lg = g;
        end else m_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        ld  = data_en[i] && ch_enable[i];
        set = 0;
        if (!ch_enable[i]) m_pend[i] = 0;
        else if (ld) begin
          set = m_pend[i] && (g != i);
          m_pend[i] = 1;
          m_sd[i] = data_in[i*BP +: BP];
          m_sl[i] = left_rightn[i];
        end else if (g == i) m_pend[i] = 0;
        if (set) m_ov[i] = 1;
        else if (clr_overrun[i]) m_ov[i] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge sck);
    #1;
    check("valid",   32'(out_valid),       32'(m_valid));
    check("data",    32'(out_data),        32'(m_data));
    check("ch",      32'(out_ch),          32'(m_ch));
    check("lr",      32'(out_left_rightn), 32'(m_lr));
    check("overrun", 32'(overrun),         32'(m_ov));
  endtask

  task automatic set_ch(input int i, input logic [BP-1:0] d, input bit lr);
    data_in[i*BP +: BP] = d;
    left_rightn[i]      = lr;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_en = '0; clr_overrun = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_in = '0; left_rightn = '0; data_en = '0;
    ch_enable = '1; clr_overrun = '0; out_ready = 1'b1;

    // reset state
    tick(); tick();
    check("rst_valid",   32'(out_valid), 0);
    check("rst_data",    32'(out_data),  0);
    check("rst_ch",      32'(out_ch),    0);
    check("rst_lr",      32'(out_left_rightn), 0);
    check("rst_overrun", 32'(overrun),   0);
    rst = 1'b0;

    // single channel, one-cycle latency after the pend edge
    set_ch(2, 24'h123456, 1'b1); data_en = 4'b0100;
    tick();
    data_en = '0;
    check("single_not_yet", 32'(out_valid), 0);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_ch",    32'(out_ch), 2);
    check("single_data",  32'(out_data), 32'h123456);
    check("single_lr",    32'(out_left_rightn), 1);
    tick();
    check("single_drain", 32'(out_valid), 0);

    // fairness after reset: 0,1,2,3 back to back
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 24'hA00000 + 24'(i), i[0]);
    data_en = '1;
    tick();
    data_en = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      check("fair_valid", 32'(out_valid), 1);
      check("fair_ch",    32'(out_ch), 32'(k));
      check("fair_data",  32'(out_data), 32'hA00000 + 32'(k));
    end
    check("fair_overrun", 32'(overrun), 0);
    tick();
    check("fair_empty", 32'(out_valid), 0);

    // stall and overrun
    do_reset();
    out_ready = 1'b0;
    set_ch(0, 24'h0F0F0F, 1'b0); data_en = 4'b0001;
    tick();
    data_en = '0;
    tick();
    set_ch(1, 24'h111111, 1'b1); data_en = 4'b0010;
    tick();
    set_ch(1, 24'h222222, 1'b0);
    tick();
    data_en = '0;
    tick();
    check("stall_overrun", 32'(overrun), 32'h2);
    check("stall_hold_ch", 32'(out_ch), 0);
    check("stall_hold_d",  32'(out_data), 32'h0F0F0F);
    out_ready = 1'b1;
    tick();
    check("stall_next_ch", 32'(out_ch), 1);
    check("stall_next_d",  32'(out_data), 32'h222222);
    tick();
    check("stall_empty", 32'(out_valid), 0);
    clr_overrun = 4'b0010;
    tick();
    clr_overrun = '0;
    check("ovr_cleared", 32'(overrun), 0);

    // same-edge load and grant on ch0
    do_reset();
    set_ch(0, 24'h000AAA, 1'b1); data_en = 4'b0001;
    tick();
    set_ch(0, 24'h000BBB, 1'b0);
    tick();
    data_en = '0;
    check("same_first",   32'(out_data), 32'h000AAA);
    check("same_no_ovr",  32'(overrun), 0);
    tick();
    check("same_second",  32'(out_data), 32'h000BBB);
    check("same_valid",   32'(out_valid), 1);
    tick();
    check("same_empty",   32'(out_valid), 0);

    // disabled channel ignores its strobe
    ch_enable = 4'b0111;
    set_ch(3, 24'hDEAD33, 1'b1); data_en = 4'b1000;
    tick();
    data_en = '0;
    tick(); tick();
    check("dis_valid",   32'(out_valid), 0);
    check("dis_overrun", 32'(overrun), 0);
    ch_enable = '1;
    tick(); tick();
    check("dis_no_late", 32'(out_valid), 0);

    // mid-stream reset while full with two pending
    out_ready = 1'b0;
    for (int i = 1; i < N; i++) set_ch(i, 24'h500000 + 24'(i), 1'b0);
    data_en = 4'b1110;
    tick();
    data_en = '0;
    tick();
    check("mid_full", 32'(out_valid), 1);
    data_en = 4'b0100;
    tick();
    data_en = '0;
    check("mid_ovr_set", 32'(overrun), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid",   32'(out_valid), 0);
    check("mid_overrun", 32'(overrun), 0);
    check("mid_data",    32'(out_data), 0);
    out_ready = 1'b1;
    tick(); tick();
    check("mid_no_pend", 32'(out_valid), 0);
    set_ch(0, 24'h0C0C00, 1'b1); set_ch(3, 24'h0C0C03, 1'b0);
    data_en = 4'b1001;
    tick();
    data_en = '0;
    tick();
    check("mid_first_ch0", 32'(out_ch), 0);
    tick();
    check("mid_then_ch3",  32'(out_ch), 3);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      ch_enable   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      data_en     = N'($urandom);
      clr_overrun = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      out_ready   = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) set_ch(i, BP'($urandom), bit'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_rx_arbiter.md
# i2s_rx_arbiter

Collects samples from `NUM_CH` I2S receiver instances and serialises them onto the single mixer input stream. Each receiver gets a one-entry holding slot. A round-robin arbiter grants slots to one registered output with a valid/ready handshake. Per-channel overruns are flagged when a receiver delivers a new sample before its previous one was drained. The block sits between the I2S receiver bank and the mixer datapath.

## Interface
Parameters:
- `NUM_CH`, 4, number of receiver channels, 2..16
- `BITS_PRECISION`, 24, sample width; matches the receivers

Ports:
- `sck`  in  1  clock; all state updates on the rising edge. Receivers update on the falling edge, so their outputs are stable here.
- `rst`  in  1  reset, synchronous and active-high
- `data_in`  in  NUM_CH*BITS_PRECISION  receiver samples; channel i is `[i*BITS_PRECISION +: BITS_PRECISION]`
- `left_rightn`  in  NUM_CH  receiver channel flag (1 = left)
- `data_en`  in  NUM_CH  one-cycle sample strobe per receiver
- `ch_enable`  in  NUM_CH  per-channel enable mask
- `clr_overrun`  in  NUM_CH  write-1-to-clear for the `overrun` bits
- `out_data`  out  BITS_PRECISION  granted sample
- `out_ch`  out  $clog2(NUM_CH)  channel index of `out_data`
- `out_left_rightn`  out  1  left/right flag of the granted sample
- `out_valid`  out  1  output register holds a sample
- `out_ready`  in  1  mixer accepts the sample
- `overrun`  out  NUM_CH  sticky per-channel overrun flags

## Operation
- **Slot load.** At an edge where `data_en[i]` and `ch_enable[i]` are both high, slot i captures `data_in` and `left_rightn`, and its `pend[i]` bit is set.
- **Overrun.** If `pend[i]` is already set and slot i is not granted at the same edge:
  - the new sample overwrites the old one;
  - `overrun[i]` is set.
- **Load and drain at the same edge.** The new sample is loaded, `pend[i]` stays 1, and no overrun is raised.
- **Disabled channel.** While `ch_enable[i]` is low, `data_en[i]` is ignored and `pend[i]` is cleared.
- **Output state machine**, two states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
  - "Free" means EMPTY, or FULL with `out_ready` = 1.
  - When free and any `pend` bit is set, the arbiter grants one channel. Its slot loads into the output register, its `pend` bit clears, and the state becomes FULL.
  - When free and no `pend` bit is set, the state becomes EMPTY.
- **Round robin.**
  - The search starts at `last_grant + 1` modulo `NUM_CH`; the first pending channel found wins.
  - `last_grant` updates on every grant.
- **Stall.** While FULL and `out_ready` = 0, all output ports hold their values. Slots continue to accept loads.
- **Overrun clear.** `clr_overrun[i]` clears `overrun[i]`. If a set and a clear happen at the same edge, the set wins.
- **Arithmetic.** `out_ch` carries the index at `$clog2(NUM_CH)` bits. No sample arithmetic is performed; data passes through bit-exact.

## Timing
- **Reset values.**
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `out_left_rightn` = 0, `overrun` = 0.
  - All `pend` bits = 0.
  - `last_grant` = `NUM_CH-1`, so channel 0 has first priority.
- **Latency.** With the output free, `data_en` sampled at edge t gives `out_valid` = 1 after edge t+1, with the sample on `out_data`.
- **Throughput.** One sample per cycle while `out_ready` stays high.
- **Handshake.** A transfer occurs at an edge where `out_valid` and `out_ready` are both 1. After `out_valid` rises, it stays high and the output is stable until that transfer. `out_valid` never depends combinationally on `out_ready`.
- **Fairness.** With all channels continuously pending, grants rotate 0,1,…,`NUM_CH-1`,0,…
- **Reset mid-operation.** At the next edge with `rst` = 1, all pending and output samples are discarded and everything returns to reset values. `out_ready` is ignored during reset.
- **Disable with a sample in the output register.** Dropping `ch_enable` does not affect a sample already in the output register; it is still delivered.

## Structure
- **Package `i2s_pkg`:**
  - the `BITS_PRECISION` default constant;
  - typedef `sample_t` = {data, left_rightn};
  - the `CH_W($clog2)` helper used for `out_ch` width.
- **Sub-module `rr_arbiter`:**
  - parameterised by `NUM_CH`;
  - inputs: request vector, `last_grant`, advance enable;
  - outputs: one-hot grant, grant index, any_grant.
- The top level holds the slots, the overrun logic and the output register/state.

## Test plan
- **Single channel.** Reset, then `NUM_CH` = 4 and `data_en[2]` pulse with data 0x123456, left = 1, `out_ready` = 1. Required: `out_valid` high after the next edge, with `out_ch` = 2, `out_data` = 0x123456, `out_left_rightn` = 1.
- **Fairness.** All four `data_en` pulse together with data 0xA0000i. Required: outputs appear in order ch0, ch1, ch2, ch3 on consecutive cycles, with matching data and no overrun.
- **Stall and overrun.** Hold `out_ready` = 0 and strobe ch1 twice (0x111111, then 0x222222). Required: `overrun[1]` = 1. After `out_ready` rises, ch1 delivers only the queued 0x222222 behind the sample already held. A `clr_overrun[1]` pulse then clears the flag.
- **Same-edge load and grant.** A ch0 slot is pending, the output is free, and `data_en[0]` fires at the grant edge. Required: no overrun, both samples are delivered in order, and `pend[0]` = 1 after that edge.
- **Disable.** With `ch_enable[3]` = 0, strobe ch3. Required: no output and no overrun.
- **Mid-stream reset.** Assert `rst` for one cycle while FULL with 2 slots pending. Required: `out_valid` = 0, all `pend` bits and `overrun` = 0, and the next grant goes to ch0 first.
